// File: rtl/serial_divider.sv
// Radix-2 restoring divider for the RV64M DIV/REM group; one quotient bit per cycle.
// Optional SERIAL_DIVIDER_EARLY_EXIT_EN finishes |dividend| < |divisor| ops in one cycle.
package serial_divider_pkg;
   typedef enum logic [3:0] {
      MUL, MULH, MULHSU, MULHU, MULW,
      DIV, DIVU, DIVW, DIVUW, REM, REMU, REMW, REMUW
   } fu_op_e;
endpackage

module serial_divider
   import serial_divider_pkg::*;
#(
   parameter int unsigned XLEN          = 64,
   parameter int unsigned TRANS_ID_BITS = 3
) (
   input  logic                     clk_i,
   input  logic                     rst_ni,
   input  logic                     flush_i,
   input  logic [TRANS_ID_BITS-1:0] trans_id_i,
   input  logic                     div_valid_i,
   input  fu_op_e                   operation_i,
   input  logic [XLEN-1:0]          operand_a_i,
   input  logic [XLEN-1:0]          operand_b_i,
   output logic                     div_ready_o,
   output logic                     div_valid_o,
   output logic [XLEN-1:0]          result_o,
   output logic [TRANS_ID_BITS-1:0] div_trans_id_o,
   input  logic                     result_ready_i
);

   localparam int unsigned CNT_W = $clog2(XLEN + 1);
   localparam int unsigned HALF  = 32;

   typedef enum logic [1:0] {IDLE, DIVIDE, FINISH} state_e;

   state_e                   state_q;
   logic [CNT_W-1:0]         cnt_q;
   logic [XLEN-1:0]          rem_q, dvd_q, dvs_q;
   logic [TRANS_ID_BITS-1:0] id_q;
   logic                     op_w_q, op_rem_q, q_neg_q, r_neg_q;

   logic            op_div_c, op_signed_c, op_w_c, op_rem_c;
   logic [XLEN-1:0] a_ext_c, b_ext_c, mag_a_c, mag_b_c, min_neg_c, fast_res_c;
   logic            sa_c, sb_c, b_zero_c, ovf_c, early_c, fast_c;
   logic [XLEN:0]   rem_sh_c;
   logic            ge_c;
   logic [XLEN-1:0] rem_nxt_c, dvd_nxt_c, q_fin_c, r_fin_c, div_res_c;

   function automatic logic [XLEN-1:0] fit_w(input logic [XLEN-1:0] v, input logic w);
      return w ? {{(XLEN-HALF){v[HALF-1]}}, v[HALF-1:0]} : v;
   endfunction

   // Opcode decode
   always_comb begin
      op_div_c    = 1'b1;
      op_signed_c = 1'b0;
      op_w_c      = 1'b0;
      op_rem_c    = 1'b0;
      case (operation_i)
         DIV:   op_signed_c = 1'b1;
         DIVU:  ;
         DIVW:  begin op_signed_c = 1'b1; op_w_c = 1'b1; end
         DIVUW: op_w_c = 1'b1;
         REM:   begin op_signed_c = 1'b1; op_rem_c = 1'b1; end
         REMU:  op_rem_c = 1'b1;
         REMW:  begin op_signed_c = 1'b1; op_w_c = 1'b1; op_rem_c = 1'b1; end
         REMUW: begin op_w_c = 1'b1; op_rem_c = 1'b1; end
         default: op_div_c = 1'b0;
      endcase
   end

   // Operand extension, magnitudes and single-cycle special cases
   always_comb begin
      a_ext_c = operand_a_i;
      b_ext_c = operand_b_i;
      if (op_w_c) begin
         a_ext_c = {{(XLEN-HALF){op_signed_c & operand_a_i[HALF-1]}}, operand_a_i[HALF-1:0]};
         b_ext_c = {{(XLEN-HALF){op_signed_c & operand_b_i[HALF-1]}}, operand_b_i[HALF-1:0]};
      end
      sa_c      = op_signed_c & a_ext_c[XLEN-1];
      sb_c      = op_signed_c & b_ext_c[XLEN-1];
      mag_a_c   = sa_c ? -a_ext_c : a_ext_c;
      mag_b_c   = sb_c ? -b_ext_c : b_ext_c;
      min_neg_c = op_w_c ? {{(XLEN-HALF+1){1'b1}}, {(HALF-1){1'b0}}}
                         : {1'b1, {(XLEN-1){1'b0}}};
      b_zero_c  = (b_ext_c == '0);
      ovf_c     = op_signed_c & (a_ext_c == min_neg_c) & (&b_ext_c);
`ifdef SERIAL_DIVIDER_EARLY_EXIT_EN
      early_c   = ~b_zero_c & (mag_a_c < mag_b_c);
`else
      early_c   = 1'b0;
`endif
      fast_c    = b_zero_c | ovf_c | early_c;
      if (b_zero_c)   fast_res_c = op_rem_c ? a_ext_c : '1;
      else if (ovf_c) fast_res_c = op_rem_c ? '0 : a_ext_c;
      else            fast_res_c = op_rem_c ? a_ext_c : '0;
   end

   // One restoring step plus the sign-corrected result of that step
   always_comb begin
      rem_sh_c  = {rem_q, dvd_q[XLEN-1]};
      ge_c      = (rem_sh_c >= {1'b0, dvs_q});
      rem_nxt_c = ge_c ? XLEN'(rem_sh_c - {1'b0, dvs_q}) : rem_sh_c[XLEN-1:0];
      dvd_nxt_c = {dvd_q[XLEN-2:0], ge_c};
      q_fin_c   = q_neg_q ? -dvd_nxt_c : dvd_nxt_c;
      r_fin_c   = r_neg_q ? -rem_nxt_c : rem_nxt_c;
      div_res_c = fit_w(op_rem_q ? r_fin_c : q_fin_c, op_w_q);
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q        <= IDLE;
         cnt_q          <= '0;
         rem_q          <= '0;
         dvd_q          <= '0;
         dvs_q          <= '0;
         id_q           <= '0;
         op_w_q         <= 1'b0;
         op_rem_q       <= 1'b0;
         q_neg_q        <= 1'b0;
         r_neg_q        <= 1'b0;
         div_ready_o    <= 1'b1;
         div_valid_o    <= 1'b0;
         result_o       <= '0;
         div_trans_id_o <= '0;
      end else if (flush_i) begin
         state_q     <= IDLE;
         div_ready_o <= 1'b1;
         div_valid_o <= 1'b0;
      end else begin
         case (state_q)
            IDLE: begin
               if (div_valid_i && div_ready_o && op_div_c) begin
                  id_q        <= trans_id_i;
                  op_w_q      <= op_w_c;
                  op_rem_q    <= op_rem_c;
                  q_neg_q     <= sa_c ^ sb_c;
                  r_neg_q     <= sa_c;
                  rem_q       <= '0;
                  dvd_q       <= op_w_c ? (mag_a_c << (XLEN - HALF)) : mag_a_c;
                  dvs_q       <= mag_b_c;
                  cnt_q       <= op_w_c ? CNT_W'(HALF) : CNT_W'(XLEN);
                  div_ready_o <= 1'b0;
                  if (fast_c) begin
                     result_o       <= fit_w(fast_res_c, op_w_c);
                     div_trans_id_o <= trans_id_i;
                     div_valid_o    <= 1'b1;
                     state_q        <= FINISH;
                  end else begin
                     state_q <= DIVIDE;
                  end
               end
            end
            DIVIDE: begin
               rem_q <= rem_nxt_c;
               dvd_q <= dvd_nxt_c;
               cnt_q <= cnt_q - CNT_W'(1);
               // Last step: publish the result on the same edge
               if (cnt_q == CNT_W'(1)) begin
                  result_o       <= div_res_c;
                  div_trans_id_o <= id_q;
                  div_valid_o    <= 1'b1;
                  state_q        <= FINISH;
               end
            end
            FINISH: begin
               if (result_ready_i) begin
                  div_valid_o <= 1'b0;
                  div_ready_o <= 1'b1;
                  state_q     <= IDLE;
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_serial_divider.sv
// Directed and random checks of serial_divider against an RV64M reference model.
module tb_serial_divider;
   import serial_divider_pkg::*;

   logic        clk_i = 1'b0;
   logic        rst_ni = 1'b0;
   logic        flush_i = 1'b0;
   logic [2:0]  trans_id_i = '0;
   logic        div_valid_i = 1'b0;
   fu_op_e      operation_i = DIV;
   logic [63:0] operand_a_i = '0;
   logic [63:0] operand_b_i = '0;
   logic        div_ready_o, div_valid_o;
   logic [63:0] result_o;
   logic [2:0]  div_trans_id_o;
   logic        result_ready_i = 1'b1;

   serial_divider #(.XLEN(64), .TRANS_ID_BITS(3)) dut (
      .clk_i(clk_i), .rst_ni(rst_ni), .flush_i(flush_i), .trans_id_i(trans_id_i),
      .div_valid_i(div_valid_i), .operation_i(operation_i),
      .operand_a_i(operand_a_i), .operand_b_i(operand_b_i),
      .div_ready_o(div_ready_o), .div_valid_o(div_valid_o), .result_o(result_o),
      .div_trans_id_o(div_trans_id_o), .result_ready_i(result_ready_i)
   );

   always #5 clk_i = ~clk_i;

   typedef struct {
      logic [63:0] res;
      logic [2:0]  id;
      int          lat;
   } exp_t;

   exp_t sb_q[$];
   int   n_vec = 0;
   int   n_err = 0;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   function automatic logic [63:0] ref_res(input fu_op_e op, input logic [63:0] a, input logic [63:0] b);
      logic [31:0] a32, b32, r32;
      logic [63:0] r;
      logic        w;
      a32 = a[31:0]; b32 = b[31:0]; r32 = '0; r = '0; w = 1'b0;
      case (op)
         DIV:  if (b == 0) r = '1;
               else if (a == 64'h8000_0000_0000_0000 && b == '1) r = a;
               else r = $signed(a) / $signed(b);
         DIVU: if (b == 0) r = '1; else r = a / b;
         REM:  if (b == 0) r = a;
               else if (a == 64'h8000_0000_0000_0000 && b == '1) r = '0;
               else r = $signed(a) % $signed(b);
         REMU: if (b == 0) r = a; else r = a % b;
         DIVW: begin
            w = 1'b1;
            if (b32 == 0) r32 = '1;
            else if (a32 == 32'h8000_0000 && b32 == '1) r32 = a32;
            else r32 = $signed(a32) / $signed(b32);
         end
         DIVUW: begin w = 1'b1; if (b32 == 0) r32 = '1; else r32 = a32 / b32; end
         REMW: begin
            w = 1'b1;
            if (b32 == 0) r32 = a32;
            else if (a32 == 32'h8000_0000 && b32 == '1) r32 = '0;
            else r32 = $signed(a32) % $signed(b32);
         end
         REMUW: begin w = 1'b1; if (b32 == 0) r32 = a32; else r32 = a32 % b32; end
         default: r = '0;
      endcase
      if (w) r = {{32{r32[31]}}, r32};
      return r;
   endfunction

   function automatic int lat_of(input fu_op_e op, input logic [63:0] a, input logic [63:0] b);
      logic        w, s;
      logic [63:0] ax, bx;
      w  = op inside {DIVW, DIVUW, REMW, REMUW};
      s  = op inside {DIV, REM, DIVW, REMW};
      ax = a; bx = b;
      if (w) begin
         ax = {{32{s & a[31]}}, a[31:0]};
         bx = {{32{s & b[31]}}, b[31:0]};
      end
      if (bx == 0) return 1;
      if (s && bx == '1 && ax == (w ? 64'hFFFF_FFFF_8000_0000 : 64'h8000_0000_0000_0000)) return 1;
`ifdef SERIAL_DIVIDER_EARLY_EXIT_EN
      begin
         logic [63:0] ma, mb;
         ma = (s && ax[63]) ? -ax : ax;
         mb = (s && bx[63]) ? -bx : bx;
         if (ma < mb) return 1;
      end
`endif
      return w ? 33 : 65;
   endfunction

   // Issue one op from a negedge, wait for its result, hold it for 'hold' cycles, then hand it off.
   task automatic run(input string tag, input fu_op_e op, input logic [63:0] a, input logic [63:0] b,
                      input logic [2:0] id, input logic [63:0] exp_res, input int exp_lat, input int hold);
      exp_t e;
      int   lat;
      e.res = exp_res; e.id = id; e.lat = exp_lat;
      sb_q.push_back(e);
      check({tag, " ready_before"}, 64'(div_ready_o), 64'd1);
      result_ready_i = (hold == 0);
      div_valid_i = 1'b1; operation_i = op; operand_a_i = a; operand_b_i = b; trans_id_i = id;
      @(posedge clk_i);
      lat = 1;
      @(negedge clk_i);
      div_valid_i = 1'b0;
      while (!div_valid_o && lat < 200) begin
         @(posedge clk_i);
         lat++;
         @(negedge clk_i);
      end
      e = sb_q.pop_front();
      check({tag, " valid"}, 64'(div_valid_o), 64'd1);
      check({tag, " result"}, result_o, e.res);
      check({tag, " trans_id"}, 64'(div_trans_id_o), 64'(e.id));
      check({tag, " latency"}, 64'(lat), 64'(e.lat));
      check({tag, " ready_while_valid"}, 64'(div_ready_o), 64'd0);
      for (int i = 0; i < hold; i++) begin
         @(posedge clk_i);
         @(negedge clk_i);
         check({tag, " held_result"}, result_o, e.res);
         check({tag, " held_id"}, 64'(div_trans_id_o), 64'(e.id));
         check({tag, " held_valid"}, 64'(div_valid_o), 64'd1);
         check({tag, " held_ready"}, 64'(div_ready_o), 64'd0);
      end
      result_ready_i = 1'b1;
      @(posedge clk_i);
      @(negedge clk_i);
      check({tag, " ready_after"}, 64'(div_ready_o), 64'd1);
      check({tag, " valid_after"}, 64'(div_valid_o), 64'd0);
   endtask

   initial begin
      fu_op_e      ops [8] = '{DIV, DIVU, DIVW, DIVUW, REM, REMU, REMW, REMUW};
      logic [63:0] ra, rb;
      int          early_lat;
      logic        saw;
`ifdef SERIAL_DIVIDER_EARLY_EXIT_EN
      early_lat = 1;
`else
      early_lat = 65;
`endif
      repeat (3) @(negedge clk_i);
      check("rst ready", 64'(div_ready_o), 64'd1);
      check("rst valid", 64'(div_valid_o), 64'd0);
      check("rst result", result_o, 64'd0);
      check("rst id", 64'(div_trans_id_o), 64'd0);
      rst_ni = 1'b1;
      @(negedge clk_i);

      run("div_100_7", DIV, 64'd100, 64'd7, 3'd3, 64'd14, 65, 0);
      run("rem_100_7", REM, 64'd100, 64'd7, 3'd4, 64'd2, 65, 0);
      run("div_m7_2", DIV, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 3'd1, 64'hFFFF_FFFF_FFFF_FFFD, 65, 0);
      run("rem_m7_2", REM, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 3'd2, 64'hFFFF_FFFF_FFFF_FFFF, 65, 0);
      run("divu_max_2", DIVU, 64'hFFFF_FFFF_FFFF_FFFF, 64'd2, 3'd5, 64'h7FFF_FFFF_FFFF_FFFF, 65, 0);
      run("divw_ovf", DIVW, 64'h0000_0001_8000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 3'd6,
          64'hFFFF_FFFF_8000_0000, 1, 0);
      run("remw_ovf", REMW, 64'h0000_0001_8000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 3'd7, 64'd0, 1, 0);
      run("divu_by0", DIVU, 64'd123, 64'd0, 3'd0, 64'hFFFF_FFFF_FFFF_FFFF, 1, 0);
      run("remu_by0", REMU, 64'd5, 64'd0, 3'd1, 64'd5, 1, 0);
      run("remuw_big", REMUW, 64'hFFFF_FFFF_FFFF_FFFB, 64'd10, 3'd2, 64'd1, 33, 0);
      run("divw_bp", DIVW, 64'd100, 64'd7, 3'd3, 64'd14, 33, 10);

      // Flush an in-flight DIV at T+20
      check("flush ready_before", 64'(div_ready_o), 64'd1);
      div_valid_i = 1'b1; operation_i = DIV; operand_a_i = 64'd1000; operand_b_i = 64'd3; trans_id_i = 3'd5;
      @(posedge clk_i);
      @(negedge clk_i);
      div_valid_i = 1'b0;
      repeat (18) @(posedge clk_i);
      @(negedge clk_i);
      flush_i = 1'b1;
      @(posedge clk_i);
      @(negedge clk_i);
      flush_i = 1'b0;
      check("flush valid", 64'(div_valid_o), 64'd0);
      check("flush ready", 64'(div_ready_o), 64'd1);
      saw = 1'b0;
      repeat (80) begin
         @(negedge clk_i);
         if (div_valid_o) saw = 1'b1;
      end
      check("flush no_result", 64'(saw), 64'd0);
      run("divu_10_3", DIVU, 64'd10, 64'd3, 3'd6, 64'd3, 65, 0);

      // Non-divide op is ignored
      div_valid_i = 1'b1; operation_i = MUL; operand_a_i = 64'd9; operand_b_i = 64'd3; trans_id_i = 3'd7;
      @(posedge clk_i);
      @(negedge clk_i);
      div_valid_i = 1'b0;
      check("mul ready", 64'(div_ready_o), 64'd1);
      saw = 1'b0;
      repeat (70) begin
         @(negedge clk_i);
         if (div_valid_o) saw = 1'b1;
      end
      check("mul no_result", 64'(saw), 64'd0);

      run("divu_3_10", DIVU, 64'd3, 64'd10, 3'd1, 64'd0, early_lat, 0);

      for (int k = 0; k < 8; k++) begin
         ra = {$urandom(), $urandom()};
         rb = {$urandom(), $urandom()} >> $urandom_range(0, 62);
         if (k == 3) ra = ra >> 40;
         run($sformatf("rand%0d", k), ops[k], ra, rb, 3'(k), ref_res(ops[k], ra, rb),
             lat_of(ops[k], ra, rb), 0);
      end

      // Asynchronous reset in the middle of a divide
      div_valid_i = 1'b1; operation_i = DIV; operand_a_i = 64'd1000; operand_b_i = 64'd3; trans_id_i = 3'd2;
      @(posedge clk_i);
      @(negedge clk_i);
      div_valid_i = 1'b0;
      repeat (5) @(negedge clk_i);
      #2 rst_ni = 1'b0;
      #1;
      check("async_rst valid", 64'(div_valid_o), 64'd0);
      check("async_rst ready", 64'(div_ready_o), 64'd1);
      @(negedge clk_i);
      rst_ni = 1'b1;
      @(negedge clk_i);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
